rs_issue: RTL

RS_ISSUE -- requirements
Module: rs_issue

---
 rtl/rs_issue.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/rs_issue.sv
// Reservation station with CDB wakeup and single-entry issue select.
// Optional macro RS_AGE_SELECT_EN: per-slot saturating age counters; the
// oldest ready entry is issued instead of the lowest-index one.
// A stalled issue (valid without ready) is pinned to its slot until it is
// accepted, so a newly ready lower-index or older entry cannot change it.

`ifndef RS_SIZE
`define RS_SIZE 4
`endif

package rs_issue_pkg;
    typedef struct packed {
        logic        busy;
        logic [7:0]  ctrl_bits;
        logic [5:0]  tag;
        logic [31:0] value_1;
        logic [31:0] value_2;
        logic [5:0]  tag_1;
        logic [5:0]  tag_2;
        logic [31:0] imm;
    } rs_entry;

    typedef struct packed {
        logic [5:0]  tag;
        logic [31:0] value;
    } cdb;
endpackage

module rs_issue
    import rs_issue_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    dispatch_valid,
    input  rs_entry                 dispatch_entry,
    input  int                      dispatch_id,
    input  cdb                      cdb1,
    input  cdb                      cdb2,
    input  logic                    flush,
    input  logic                    issue_ready,
    output logic                    issue_valid,
    output rs_entry                 issue_entry,
    output int                      issue_id,
    output rs_entry [`RS_SIZE-1:0]  res_stations,
    output int                      rs_count,
    output logic                    rs_full
);

    localparam int N = `RS_SIZE;

    rs_entry [N-1:0] rs_q;
    rs_entry [N-1:0] rs_next;
    logic [N-1:0]    ready;
    logic            hold_valid_q;
    int              hold_id_q;
    logic            sel_found;
    int              sel_id;
    logic            issue_fire;
    logic            dispatch_hit;

`ifdef RS_AGE_SELECT_EN
    localparam int AGE_W = $clog2(N) + 1;
    logic [AGE_W-1:0] age_q    [N];
    logic [AGE_W-1:0] age_next [N];
    logic [AGE_W-1:0] best_age;
`endif

    // Resolve pending source tags against both broadcast buses; cdb1 wins.
    function automatic rs_entry wake(input rs_entry e, input cdb c1, input cdb c2);
        rs_entry r;
        r = e;
        if (e.tag_1 != '0) begin
            if (c1.tag != '0 && c1.tag == e.tag_1) begin
                r.value_1 = c1.value;
                r.tag_1   = '0;
            end else if (c2.tag != '0 && c2.tag == e.tag_1) begin
                r.value_1 = c2.value;
                r.tag_1   = '0;
            end
        end
        if (e.tag_2 != '0) begin
            if (c1.tag != '0 && c1.tag == e.tag_2) begin
                r.value_2 = c1.value;
                r.tag_2   = '0;
            end else if (c2.tag != '0 && c2.tag == e.tag_2) begin
                r.value_2 = c2.value;
                r.tag_2   = '0;
            end
        end
        return r;
    endfunction

    // Per-slot readiness: busy with both operands resolved.
    always_comb begin
        ready = '0;
        for (int i = 0; i < N; i++) begin
            ready[i] = rs_q[i].busy && (rs_q[i].tag_1 == '0) && (rs_q[i].tag_2 == '0);
        end
    end

    // Issue select: lowest index (or oldest), overridden by a pinned stalled slot.
    always_comb begin
        sel_found = 1'b0;
        sel_id    = 0;
`ifdef RS_AGE_SELECT_EN
        best_age  = '0;
        for (int i = 0; i < N; i++) begin
            if (ready[i] && (!sel_found || age_q[i] > best_age)) begin
                sel_found = 1'b1;
                sel_id    = i;
                best_age  = age_q[i];
            end
        end
`else
        for (int i = 0; i < N; i++) begin
            if (ready[i] && !sel_found) begin
                sel_found = 1'b1;
                sel_id    = i;
            end
        end
`endif
        for (int i = 0; i < N; i++) begin
            if (hold_valid_q && hold_id_q == i && ready[i]) begin
                sel_found = 1'b1;
                sel_id    = i;
            end
        end
    end

    // Issue outputs; zeroed when nothing is issuable or a flush is in progress.
    always_comb begin
        issue_valid = sel_found && !flush;
        issue_id    = issue_valid ? sel_id : 0;
        issue_entry = '0;
        for (int i = 0; i < N; i++) begin
            if (issue_valid && sel_id == i) begin
                issue_entry = rs_q[i];
            end
        end
        issue_fire = issue_valid && issue_ready;
    end

    // Next array: wakeup, issue release, dispatch write; flush wipes everything.
    always_comb begin
        rs_next      = rs_q;
        dispatch_hit = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (rs_q[i].busy) begin
                rs_next[i] = wake(rs_q[i], cdb1, cdb2);
            end
            if (issue_fire && issue_id == i) begin
                rs_next[i].busy = 1'b0;
            end
            if (dispatch_valid && dispatch_id == i && !rs_q[i].busy) begin
                rs_next[i]      = wake(dispatch_entry, cdb1, cdb2);
                rs_next[i].busy = 1'b1;
                dispatch_hit    = 1'b1;
            end
        end
        if (flush) begin
            rs_next      = '0;
            dispatch_hit = 1'b0;
        end
    end

`ifdef RS_AGE_SELECT_EN
    // Age update: new entry starts at 0, every other busy slot ages by one.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            age_next[i] = age_q[i];
            if (flush) begin
                age_next[i] = '0;
            end else if (dispatch_hit) begin
                if (dispatch_id == i) begin
                    age_next[i] = '0;
                end else if (rs_q[i].busy && age_q[i] != '1) begin
                    age_next[i] = age_q[i] + 1'b1;
                end
            end
        end
    end

    // Age counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) begin
                age_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                age_q[i] <= age_next[i];
            end
        end
    end
`endif

    // Station array and stall pin registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rs_q         <= '0;
            hold_valid_q <= 1'b0;
            hold_id_q    <= 0;
        end else begin
            rs_q         <= rs_next;
            hold_valid_q <= issue_valid && !issue_ready;
            hold_id_q    <= issue_id;
        end
    end

    // Occupancy from busy bits.
    always_comb begin
        rs_count = 0;
        for (int i = 0; i < N; i++) begin
            rs_count = rs_count + {31'b0, rs_q[i].busy};
        end
        rs_full = (rs_count == N);
    end

    assign res_stations = rs_q;

endmodule
